operand_regfile: RTL and testbench
==================================

OPERAND_REGFILE -- requirements
Module: operand_regfile

Interface
REQ-001 SHALL have parameter N, default 16, data width of each register and of the ALU A/B operands.
REQ-002 SHALL have parameter R, default 8, number of architectural registers; the select width is log2(R), which is 3 at the default.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port read1RegSel, input, 3 bits: register index feeding ALU operand A.
REQ-006 SHALL have port read2RegSel, input, 3 bits: register index feeding ALU operand B.
REQ-007 SHALL have port writeRegSel, input, 3 bits: destination register index from writeback.
REQ-008 SHALL have port writeData, input, N bits: writeback value, i.e. ALU Out or memory data.
REQ-009 SHALL have port writeEn, input, 1 bit: writeback valid.
REQ-010 SHALL have port read1Data, output, N bits: operand A to the ALU.
REQ-011 SHALL have port read2Data, output, N bits: operand B to the ALU.
REQ-012 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-013 SHALL hold R registers of N bits each; R0 is an ordinary, writable register.
REQ-014 SHALL present read data combinationally (zero-cycle latency) from the select inputs.
REQ-015 SHALL write writeData into register writeRegSel on a rising clk edge when writeEn=1 and rst=0.
REQ-016 SHALL perform no register update on a clock edge when writeEn=0.
REQ-017 SHALL bypass same-cycle writes: if writeEn=1 and writeRegSel==read1RegSel, read1Data equals writeData in that same cycle; port 2 behaves identically.
REQ-018 SHALL bypass both read ports simultaneously when both selects match writeRegSel.
REQ-019 SHALL not bypass while rst=1: during reset, read data is the post-reset stored value, 0.
REQ-020 SHALL provide no write-write conflict case, since there is only one write port.
REQ-021 SHALL set err at a clock edge when writeEn=1 and any bit of writeData or writeRegSel is X/Z (simulation-only check); err stays 1 until rst.
REQ-022 SHALL give a read of an index never written since reset the value 0.

Reset
REQ-023 SHALL, on a rising clk edge with rst=1, clear all R registers to 0 and clear err to 0, regardless of writeEn.
REQ-024 SHALL drop a write coincident with reset.
REQ-025 SHALL drive read1Data=0 and read2Data=0 from the cycle after the reset edge until the first write.
REQ-026 SHALL take effect for a reset asserted mid-stream on the next edge; no write in progress survives it.

Structure
REQ-027 SHALL place N, R and the select width in a shared processor constants package, the same one that holds the ALU width N=16.
REQ-028 SHALL use one sub-module, reg16, a single N-bit register with synchronous active-high reset and write enable, instantiated R times.
REQ-029 SHALL place the bypass muxes and err logic in operand_regfile itself, with no further hierarchy.
REQ-030 SHALL drive the ALU A and B ports directly from read1Data and read2Data.

Verification
REQ-031 SHALL cover: rst=1 for one edge, then read selects 0 through 7 -> all read data 16'h0000 and err=0.
REQ-032 SHALL cover: write R3=16'hBEEF, then next cycle read1RegSel=3 and read2RegSel=3 -> both 16'hBEEF.
REQ-033 SHALL cover: writeEn=1, writeRegSel=5, writeData=16'h1234, read1RegSel=5 in the same cycle -> read1Data=16'h1234 before the edge; read2RegSel=4 -> read2Data holds R4's old value.
REQ-034 SHALL cover: R2=16'h00FF, then writeEn=0 with writeData=16'hFFFF to R2 -> R2 still 16'h00FF.
REQ-035 SHALL cover: R7=16'h8000, then rst=1 together with a write of 16'h5555 to R7 -> R7=16'h0000 after the edge.
REQ-036 SHALL cover: writeEn=1 with writeData=16'hxxxx -> err=1 after the edge and held until the next rst edge.

Source files
------------

// File: rtl/operand_regfile_pkg.sv
// Shared processor constants: ALU/register width, register count and select width.
package operand_regfile_pkg;
  localparam int unsigned N     = 16;
  localparam int unsigned R     = 8;
  localparam int unsigned SEL_W = $clog2(R);
endpackage

// File: rtl/operand_regfile_reg16.sv
// Single N-bit register with synchronous active-high reset and write enable.
module reg16
  import operand_regfile_pkg::*;
#(
  parameter int unsigned W = N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) q_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/operand_regfile.sv
// Two-read, one-write operand register file with same-cycle write bypass and sticky X-write error flag.
module operand_regfile
  import operand_regfile_pkg::*;
#(
  parameter int unsigned N = operand_regfile_pkg::N,
  parameter int unsigned R = operand_regfile_pkg::R
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [$clog2(R)-1:0] read1RegSel,
  input  logic [$clog2(R)-1:0] read2RegSel,
  input  logic [$clog2(R)-1:0] writeRegSel,
  input  logic [N-1:0]         writeData,
  input  logic                 writeEn,
  output logic [N-1:0]         read1Data,
  output logic [N-1:0]         read2Data,
  output logic                 err
);

  localparam int unsigned SW = $clog2(R);

  logic [N-1:0] rf_q [R];
  logic [R-1:0] we_vec;
  logic         err_q;
  logic         err_d;

  for (genvar i = 0; i < R; i++) begin : g_reg
    assign we_vec[i] = writeEn && (writeRegSel == SW'(i));
    reg16 #(.W(N)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .we_i (we_vec[i]),
      .d_i  (writeData),
      .q_o  (rf_q[i])
    );
  end

  // Reads see a same-cycle write, but reset forces the post-reset value.
  always_comb begin
    read1Data = rf_q[read1RegSel];
    read2Data = rf_q[read2RegSel];
    if (rst) begin
      read1Data = '0;
      read2Data = '0;
    end else if (writeEn) begin
      if (writeRegSel == read1RegSel) read1Data = writeData;
      if (writeRegSel == read2RegSel) read2Data = writeData;
    end
  end

  // Unknown bits on a valid write latch err until reset; only visible in 4-state simulation.
  always_comb begin
    err_d = err_q;
    if (writeEn && $isunknown({writeData, writeRegSel})) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Randomized self-checking bench for operand_regfile against an array-based reference model.
module tb_operand_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read1RegSel, read2RegSel, writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic [15:0] read1Data, read2Data;
  logic        err;

  logic [15:0] mem [8];
  logic        err_m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  operand_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .err         (err)
  );

  // Expected combinational read value from the current inputs and stored model state.
  function automatic logic [15:0] exp_rd(input logic [2:0] sel);
    if (rst) return 16'h0000;
    if (writeEn && writeRegSel == sel) return writeData;
    return mem[sel];
  endfunction

  task automatic drive(input logic r, input logic we, input logic [2:0] ws,
                       input logic [15:0] wd, input logic [2:0] s1, input logic [2:0] s2);
    @(negedge clk);
    rst = r; writeEn = we; writeRegSel = ws; writeData = wd;
    read1RegSel = s1; read2RegSel = s2;
    #1;
  endtask

  // Advance one rising edge and apply the architectural update rules to the model.
  task automatic edge_update();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
      err_m = 1'b0;
    end else if (writeEn) begin
      if ($isunknown({writeData, writeRegSel})) err_m = 1'b1;
      if (!$isunknown(writeRegSel)) mem[writeRegSel] = writeData;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 3'd1, 16'hA5A5, 3'd1, 3'd1);
    checks++;
    if (read1Data !== 16'h0000) begin
      errors++; $display("FAIL reset_no_bypass got %h want 0000", read1Data);
    end
    edge_update();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
      checks++;
      if (read1Data !== 16'h0000 || read2Data !== 16'h0000) begin
        errors++; $display("FAIL reset_read sel=%0d got %h/%h want 0000/0000", i, read1Data, read2Data);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", err);
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1);
    edge_update();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
    checks++;
    if (read1Data !== 16'hBEEF || read2Data !== 16'hBEEF) begin
      errors++; $display("FAIL write_read got %h/%h want beef/beef", read1Data, read2Data);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] v;
    v = 16'($urandom);
    drive(1'b0, 1'b1, 3'd4, v, 3'd0, 3'd0);
    edge_update();
    drive(1'b0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd4);
    checks++;
    if (read1Data !== 16'h1234) begin
      errors++; $display("FAIL bypass_p1 got %h want 1234", read1Data);
    end
    checks++;
    if (read2Data !== v) begin
      errors++; $display("FAIL bypass_p2_old got %h want %h", read2Data, v);
    end
    edge_update();
    drive(1'b0, 1'b1, 3'd6, 16'hC0DE, 3'd6, 3'd6);
    checks++;
    if (read1Data !== 16'hC0DE || read2Data !== 16'hC0DE) begin
      errors++; $display("FAIL bypass_both got %h/%h want c0de/c0de", read1Data, read2Data);
    end
    edge_update();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd6);
    checks++;
    if (read1Data !== 16'h1234 || read2Data !== 16'hC0DE) begin
      errors++; $display("FAIL bypass_stored got %h/%h want 1234/c0de", read1Data, read2Data);
    end
  endtask

  task automatic test_write_disable();
    drive(1'b0, 1'b1, 3'd2, 16'h00FF, 3'd0, 3'd0);
    edge_update();
    drive(1'b0, 1'b0, 3'd2, 16'hFFFF, 3'd2, 3'd2);
    checks++;
    if (read1Data !== 16'h00FF) begin
      errors++; $display("FAIL we0_nobypass got %h want 00ff", read1Data);
    end
    edge_update();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd0);
    checks++;
    if (read1Data !== 16'h00FF) begin
      errors++; $display("FAIL we0_hold got %h want 00ff", read1Data);
    end
  endtask

  task automatic test_reset_write();
    drive(1'b0, 1'b1, 3'd7, 16'h8000, 3'd0, 3'd0);
    edge_update();
    drive(1'b1, 1'b1, 3'd7, 16'h5555, 3'd7, 3'd2);
    edge_update();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd2);
    checks++;
    if (read1Data !== 16'h0000 || read2Data !== 16'h0000) begin
      errors++; $display("FAIL reset_drops_write got %h/%h want 0000/0000", read1Data, read2Data);
    end
  endtask

  task automatic test_err();
    drive(1'b0, 1'b1, 3'd1, 16'hxxxx, 3'd0, 3'd0);
    edge_update();
    checks++;
    if (err !== err_m) begin
      errors++; $display("FAIL err_set got %b want %b", err, err_m);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 3'd0, 16'($urandom), 3'd0, 3'd0);
      edge_update();
      checks++;
      if (err !== err_m) begin
        errors++; $display("FAIL err_sticky k=%0d got %b want %b", k, err, err_m);
      end
    end
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    edge_update();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b want 0", err);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
            3'($urandom), 3'($urandom));
      checks++;
      if (read1Data !== exp_rd(read1RegSel) || read2Data !== exp_rd(read2RegSel)) begin
        errors++;
        $display("FAIL random_read n=%0d got %h/%h want %h/%h", n, read1Data, read2Data,
                 exp_rd(read1RegSel), exp_rd(read2RegSel));
      end
      edge_update();
      checks++;
      if (err !== err_m) begin
        errors++; $display("FAIL random_err n=%0d got %b want %b", n, err, err_m);
      end
    end
  endtask

  initial begin
    rst = 1'b1; writeEn = 1'b0; writeRegSel = '0; writeData = '0;
    read1RegSel = '0; read2RegSel = '0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    err_m = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_write_disable();
    test_reset_write();
    test_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
